// File: rtl/tdm_demux.sv
// TDM word-link receiver: tracks slot position, gathers one frame in shadow
// registers and commits it atomically to q. Optional parity: TDM_DEMUX_PARITY_EN.
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [WIDTH-1:0]          d,
  input  logic                      d_valid,
  input  logic                      sync,
  input  logic                      err_clr,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic                      q_valid,
  output logic                      locked,
  output logic [$clog2(CHANNELS)-1:0] slot,
  output logic                      sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  input  logic                      d_par,
  output logic                      par_err
`endif
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0] SLOT_ZERO = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(CHANNELS - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [SEL_W-1:0]            slot_q, slot_d;
  logic [WIDTH-1:0]            shadow_q [CHANNELS-1];
  logic [WIDTH-1:0]            shadow_d [CHANNELS-1];
  logic [CHANNELS*WIDTH-1:0]   q_q, q_d;
  logic                        q_valid_q, q_valid_d;
  logic                        sync_err_q, sync_err_d;
  logic                        commit_ok_s;
  logic                        beat_bad_s;

`ifdef TDM_DEMUX_PARITY_EN
  logic                        bad_q, bad_d;
  logic                        par_err_q, par_err_d;

  // Odd parity: a good beat has an odd number of ones across d and d_par.
  function automatic logic par_bad(input logic [WIDTH-1:0] data, input logic par);
    par_bad = ~(^{data, par});
  endfunction

  assign beat_bad_s  = par_bad(d, d_par);
  assign commit_ok_s = ~(bad_q | beat_bad_s);
  assign par_err     = par_err_q;
`else
  assign beat_bad_s  = 1'b0;
  assign commit_ok_s = ~beat_bad_s;
`endif

  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign locked   = (state_q == LOCKED);
  assign slot     = slot_q;
  assign sync_err = sync_err_q;

  // Next-state logic for slot tracking, shadow capture, commit and error flags.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    shadow_d   = shadow_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    // A new error below overrides the clear, so err_clr never masks it.
    sync_err_d = sync_err_q & ~err_clr;
`ifdef TDM_DEMUX_PARITY_EN
    bad_d      = bad_q;
    par_err_d  = par_err_q & ~err_clr;
`endif
    if (d_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[0] = d;
            slot_d      = SLOT_ONE;
            state_d     = LOCKED;
`ifdef TDM_DEMUX_PARITY_EN
            bad_d       = beat_bad_s;
`endif
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (sync) begin
            if (slot_q != SLOT_ZERO) begin
              sync_err_d = 1'b1;
            end else begin
              sync_err_d = sync_err_d;
            end
            shadow_d[0] = d;
            slot_d      = SLOT_ONE;
`ifdef TDM_DEMUX_PARITY_EN
            bad_d       = beat_bad_s;
`endif
          end else if (slot_q == SLOT_ZERO) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            slot_d     = SLOT_ZERO;
`ifdef TDM_DEMUX_PARITY_EN
            bad_d      = 1'b0;
`endif
          end else if (slot_q == SLOT_LAST) begin
            slot_d = SLOT_ZERO;
            if (commit_ok_s) begin
              for (int k = 0; k < CHANNELS - 1; k++) begin
                q_d[k*WIDTH +: WIDTH] = shadow_q[k];
              end
              q_d[(CHANNELS-1)*WIDTH +: WIDTH] = d;
              q_valid_d = 1'b1;
            end else begin
`ifdef TDM_DEMUX_PARITY_EN
              par_err_d = 1'b1;
`endif
              q_valid_d = 1'b0;
            end
`ifdef TDM_DEMUX_PARITY_EN
            bad_d = 1'b0;
`endif
          end else begin
            for (int k = 0; k < CHANNELS - 1; k++) begin
              if (slot_q == SEL_W'(k)) begin
                shadow_d[k] = d;
              end else begin
                shadow_d[k] = shadow_q[k];
              end
            end
            slot_d = slot_q + SLOT_ONE;
`ifdef TDM_DEMUX_PARITY_EN
            bad_d  = bad_q | beat_bad_s;
`endif
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = SLOT_ZERO;
        end
      endcase
    end else begin
      q_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= HUNT;
      slot_q     <= SLOT_ZERO;
      q_q        <= {(CHANNELS*WIDTH){1'b0}};
      q_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
      for (int k = 0; k < CHANNELS - 1; k++) begin
        shadow_q[k] <= {WIDTH{1'b0}};
      end
`ifdef TDM_DEMUX_PARITY_EN
      bad_q      <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      sync_err_q <= sync_err_d;
      shadow_q   <= shadow_d;
`ifdef TDM_DEMUX_PARITY_EN
      bad_q      <= bad_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

endmodule
